// File: rtl/click_classifier.sv
// Groups one-cycle press pulses from the debounce stage into bursts and reports
// each burst as a single, double or triple click once it closes.
module click_classifier #(
  parameter logic [31:0] WINDOW     = 32'd1 << 22,
  parameter int unsigned MAX_CLICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  output logic       event_valid,
  output logic [1:0] click_count,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    COUNTING
  } state_t;

  localparam logic [31:0] TIMER_LAST = WINDOW - 32'd1;
  localparam logic [1:0]  LIMIT      = 2'(MAX_CLICKS);

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [31:0] timer, timer_next;
  logic        event_next;
  logic [1:0]  count_next;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    timer_next = timer;
    event_next = 1'b0;
    count_next = click_count;
    case (state)
      IDLE: begin
        if (pulse) begin
          cnt_next   = 2'd1;
          timer_next = '0;
          if (LIMIT == 2'd1) begin
            event_next = 1'b1;
            count_next = 2'd1;
          end else begin
            state_next = COUNTING;
          end
        end
      end
      COUNTING: begin
        // A pulse on the timeout edge is checked first, so it extends the burst.
        if (pulse) begin
          if (cnt + 2'd1 == LIMIT) begin
            event_next = 1'b1;
            count_next = LIMIT;
            state_next = IDLE;
          end else begin
            cnt_next   = cnt + 2'd1;
            timer_next = '0;
          end
        end else if (timer == TIMER_LAST) begin
          event_next = 1'b1;
          count_next = cnt;
          state_next = IDLE;
        end else begin
          timer_next = timer + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      event_valid <= 1'b0;
      click_count <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      timer       <= timer_next;
      event_valid <= event_next;
      click_count <= count_next;
    end
  end

  assign busy = (state == COUNTING);

endmodule

// File: tb/tb_click_classifier.sv
// Scoreboard bench for click_classifier: one instance with a three-click limit,
// one with a single-click limit, both with an eight-cycle silence window.
module tb_click_classifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse3 = 1'b0, pulse1 = 1'b0;
  logic       ev3, ev1, busy3, busy1;
  logic [1:0] cc3, cc1;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         at_edge;
    logic [1:0] count;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];

  click_classifier #(.WINDOW(32'd8), .MAX_CLICKS(3)) dut3 (
    .clk(clk), .rst(rst), .pulse(pulse3),
    .event_valid(ev3), .click_count(cc3), .busy(busy3)
  );

  click_classifier #(.WINDOW(32'd8), .MAX_CLICKS(1)) dut1 (
    .clk(clk), .rst(rst), .pulse(pulse1),
    .event_valid(ev1), .click_count(cc1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: every observed event must match the oldest expected one.
  always @(negedge clk) begin
    if (ev3) begin
      n_tests++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL dut3_unexpected_event: edge %0d count %0d, expected no event", cyc, cc3);
      end else begin
        exp_t e;
        e = q3.pop_front();
        if (e.at_edge !== cyc || e.count !== cc3) begin
          n_fail++;
          $display("FAIL dut3_event: got edge %0d count %0d, expected edge %0d count %0d",
                   cyc, cc3, e.at_edge, e.count);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ev1) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected_event: edge %0d count %0d, expected no event", cyc, cc1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (e.at_edge !== cyc || e.count !== cc1) begin
          n_fail++;
          $display("FAIL dut1_event: got edge %0d count %0d, expected edge %0d count %0d",
                   cyc, cc1, e.at_edge, e.count);
        end
      end
    end
  end

  function automatic logic [31:0] bits(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Edges are numbered relative to the call; must be called right after a negedge.
  task automatic expect_event(input bit sel, input int rel_edge, input logic [1:0] count);
    exp_t e;
    e.at_edge = cyc + rel_edge;
    e.count   = count;
    if (sel) q1.push_back(e);
    else     q3.push_back(e);
  endtask

  // Drives pmask[k] into edge k and checks busy after each edge against bmask[k].
  task automatic run(input bit sel, input logic [31:0] pmask, input logic [31:0] bmask,
                     input int n, input string name);
    for (int k = 1; k <= n; k++) begin
      if (sel) pulse1 = pmask[k];
      else     pulse3 = pmask[k];
      @(negedge clk);
      n_tests++;
      if ((sel ? busy1 : busy3) !== bmask[k]) begin
        n_fail++;
        $display("FAIL %s_busy: edge %0d got %b expected %b", name, k,
                 sel ? busy1 : busy3, bmask[k]);
      end
    end
    pulse1 = 1'b0;
    pulse3 = 1'b0;
    n_tests++;
    if ((sel ? q1.size() : q3.size()) != 0) begin
      n_fail++;
      $display("FAIL %s_missing_event: %0d expected events not seen", name,
               sel ? q1.size() : q3.size());
      q1.delete();
      q3.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ev3, cc3, busy3} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_dut3: got ev=%b cc=%0d busy=%b expected all 0", ev3, cc3, busy3);
    end
    n_tests++;
    if ({ev1, cc1, busy1} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: got ev=%b cc=%0d busy=%b expected all 0", ev1, cc1, busy1);
    end
    rst = 1'b0;
    run(1'b0, '0, '0, 4, "post_reset_idle");
  endtask

  task automatic test_single();
    expect_event(1'b0, 18, 2'd1);
    run(1'b0, 32'd1 << 10, bits(10, 17), 20, "single");
  endtask

  task automatic test_double();
    expect_event(1'b0, 23, 2'd2);
    run(1'b0, (32'd1 << 10) | (32'd1 << 15), bits(10, 22), 28, "double");
  endtask

  task automatic test_saturation();
    expect_event(1'b0, 14, 2'd3);
    expect_event(1'b0, 23, 2'd1);
    run(1'b0, (32'd1 << 10) | (32'd1 << 12) | (32'd1 << 14) | (32'd1 << 15),
        bits(10, 13) | bits(15, 22), 28, "saturation");
  endtask

  task automatic test_timeout_tie();
    expect_event(1'b0, 26, 2'd2);
    run(1'b0, (32'd1 << 10) | (32'd1 << 18), bits(10, 25), 30, "timeout_tie");
  endtask

  task automatic test_reset_mid_burst();
    run(1'b0, (32'd1 << 1) | (32'd1 << 3), bits(1, 4), 4, "pre_reset_burst");
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({ev3, cc3, busy3} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_burst_reset: got ev=%b cc=%0d busy=%b expected all 0", ev3, cc3, busy3);
    end
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, '0, '0, 20, "after_mid_reset");
    n_tests++;
    if (cc3 !== 2'd0) begin
      n_fail++;
      $display("FAIL after_mid_reset_count: got %0d expected 0", cc3);
    end
  endtask

  task automatic test_back_to_back();
    expect_event(1'b1, 2, 2'd1);
    expect_event(1'b1, 3, 2'd1);
    expect_event(1'b1, 4, 2'd1);
    run(1'b1, bits(2, 4), '0, 8, "max1_held");
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_saturation();
    test_timeout_tie();
    test_reset_mid_burst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/click_classifier.md
# click_classifier

Counts the one-cycle press pulses produced by the push-button debounce stage and classifies each burst as a single, double or triple click. A burst ends either on a silence timeout or when the click limit is reached. The block then emits one-cycle event with the click count. It sits directly downstream of the debounce stage and feeds the UI/control logic.

## Interface
- `WINDOW`, default 32'd1<<22: silence window in clk cycles; minimum 2.
- `MAX_CLICKS`, default 3: click limit in 1..3; reaching it ends the burst immediately.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `pulse`  in  1  one-cycle press pulse from the debounce stage; a pulse held high is counted once per cycle it is high.
- `event_valid`  out  1  one-cycle strobe: a burst has been classified.
- `click_count`  out  2  number of clicks in the burst (1..MAX_CLICKS). Valid while `event_valid` is high; holds its value until the next event.
- `busy`  out  1  high while a burst is open (state COUNTING).

## Operation
- States:
  - IDLE (reset state).
  - COUNTING.
- Internal registers:
  - `cnt`: 2 bits.
  - `timer`: 32 bits, compared against WINDOW-1.
- IDLE:
  - `pulse`=1: set cnt=1 and timer=0.
    - If MAX_CLICKS==1, emit immediately: event_valid=1, click_count=1, stay IDLE.
    - Otherwise go to COUNTING.
  - `pulse`=0: nothing changes.
- COUNTING, `pulse`=1:
  - cnt+1==MAX_CLICKS: emit, with event_valid=1, click_count=MAX_CLICKS, go to IDLE.
  - Otherwise: cnt=cnt+1, timer=0, stay COUNTING.
- COUNTING, `pulse`=0:
  - timer==WINDOW-1: emit, with event_valid=1, click_count=cnt, go to IDLE.
  - Otherwise: timer=timer+1.
- Simultaneous pulse and timeout (pulse=1 on the edge where timer==WINDOW-1): the pulse wins. It is counted, and the window restarts, or the burst saturates if the limit is hit.
- `event_valid` is registered. It is high for exactly the one cycle after the emitting edge and is cleared on every other edge.
- `busy` equals (state==COUNTING).
- A pulse on the cycle right after an emit is seen in IDLE and opens a new burst; no clicks are lost.
- The timer never wraps; it is bounded by WINDOW-1.

## Timing
- Reset values:
  - state=IDLE, cnt=0, timer=0.
  - event_valid=0, click_count=0, busy=0.
- Reset asserted mid-burst: the burst is discarded and no event is emitted. After release the block is in IDLE.
- Timeout latency: last pulse sampled at edge t → event_valid high in the cycle after edge t+WINDOW.
- Saturation latency: the saturating pulse sampled at edge t → event_valid high in the cycle after edge t.
- Throughput: at most one event per cycle. Back-to-back events are possible only with MAX_CLICKS==1 and continuous pulses.
- Gap between clicks of one burst: at most WINDOW cycles. A gap of exactly WINDOW cycles still counts as the same burst, because the pulse wins the tie.

## Test plan
All scenarios use WINDOW=8.
- **Reset:** assert rst while in COUNTING with cnt=2 → all outputs 0; no event_valid at any later point without a new pulse.
- **Single click (MAX_CLICKS=3):** pulse at edge 10 → busy=1 from edge 10; event_valid=1 with click_count=1 in the cycle after edge 18; busy=0 after edge 18.
- **Double click (MAX_CLICKS=3):** pulses at edges 10 and 15 → exactly one event, click_count=2, after edge 23.
- **Saturation (MAX_CLICKS=3):**
  - Pulses at edges 10, 12 and 14 → event, click_count=3, after edge 14.
  - A further pulse at edge 15 opens a new burst → event, click_count=1, after edge 23.
- **Timeout tie (MAX_CLICKS=3):** pulse at edge 10, second pulse at edge 18 (the timeout edge) → no event at 18; one event, click_count=2, after edge 26.
- **MAX_CLICKS=1:** pulse held high for 3 cycles → three consecutive one-cycle events, each with click_count=1; busy stays 0 throughout.
